// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: keeps the fetch PC, issues single outstanding ROM reads and
// buffers returned words with their addresses in a small prefetch FIFO for decode.
module fetch_prefetch #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        PC_STEP  = 1,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         reqOut,
  output logic [ADDR_W-1:0]            addrOut,
  input  logic                         ackIn,
  input  logic [DATA_W-1:0]            dataIn,
  output logic                         validOut,
  output logic [DATA_W-1:0]            dataOut,
  output logic [ADDR_W-1:0]            pcOut,
  input  logic                         readyIn,
  input  logic                         redirectIn,
  input  logic [ADDR_W-1:0]            redirectPcIn,
  output logic [$clog2(DEPTH+1)-1:0]   levelOut
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} fetchStateT;

  fetchStateT stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic              reqQ, reqD;
  logic [PTR_W-1:0]  wrPtrQ, wrPtrD;
  logic [PTR_W-1:0]  rdPtrQ, rdPtrD;
  logic [LVL_W-1:0]  levelQ, levelD;

  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [ADDR_W-1:0] pcMem   [DEPTH];

  logic              headValid;
  logic              doPush;
  logic              doPop;
  logic              flush;
  logic [ADDR_W-1:0] pcInc;
  logic [LVL_W-1:0]  levelAfterAck;

  assign headValid = (levelQ != '0);
  assign pcInc     = pcQ + ADDR_W'(PC_STEP);

  // A redirect discards whatever the FIFO would have done this edge.
  assign flush = redirectIn;
  assign doPop = headValid && readyIn && !flush;

  // Occupancy if the word returning now is pushed; levelQ < DEPTH is guaranteed in StWait.
  assign levelAfterAck = doPop ? levelQ : (levelQ + LVL_W'(1));

  always_comb begin
    stateD = stateQ;
    pcD    = pcQ;
    addrD  = addrQ;
    doPush = 1'b0;
    if (redirectIn) begin
      pcD = redirectPcIn;
      unique case (stateQ)
        StIdle:  stateD = StIdle;
        StWait:  stateD = ackIn ? StIdle : StDrop;
        StDrop:  stateD = ackIn ? StIdle : StDrop;
        default: stateD = StIdle;
      endcase
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (levelQ < FULL_LVL) begin
            stateD = StWait;
            addrD  = pcQ;
          end
        end
        StWait: begin
          if (ackIn) begin
            doPush = 1'b1;
            pcD    = pcInc;
            if (levelAfterAck < FULL_LVL) begin
              stateD = StWait;
              addrD  = pcInc;
            end else begin
              stateD = StIdle;
            end
          end
        end
        StDrop: begin
          if (ackIn) begin
            stateD = StIdle;
          end
        end
        default: stateD = StIdle;
      endcase
    end
    reqD = (stateD != StIdle);
  end

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    levelD = levelQ;
    if (flush) begin
      wrPtrD = '0;
      rdPtrD = '0;
      levelD = '0;
    end else begin
      if (doPush) begin
        wrPtrD = wrPtrQ + PTR_W'(1);
      end
      if (doPop) begin
        rdPtrD = rdPtrQ + PTR_W'(1);
      end
      if (doPush && !doPop) begin
        levelD = levelQ + LVL_W'(1);
      end else if (!doPush && doPop) begin
        levelD = levelQ - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
      pcQ    <= RESET_PC;
      addrQ  <= '0;
      reqQ   <= 1'b0;
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      levelQ <= '0;
    end else begin
      stateQ <= stateD;
      pcQ    <= pcD;
      addrQ  <= addrD;
      reqQ   <= reqD;
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      levelQ <= levelD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && doPush) begin
      dataMem[wrPtrQ] <= dataIn;
      pcMem[wrPtrQ]   <= pcQ;
    end
  end

  assign reqOut   = reqQ;
  assign addrOut  = addrQ;
  assign validOut = headValid;
  assign dataOut  = headValid ? dataMem[rdPtrQ] : '0;
  assign pcOut    = headValid ? pcMem[rdPtrQ] : '0;
  assign levelOut = levelQ;

endmodule
